multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the RV32I core: replaces the single-cycle decode with a Moore FSM that steps a shared-memory datapath (one memory port, IR, OldPC, A/B, ALUOut and Data registers) through fetch, decode, execute, memory and writeback. It decodes ADD, SUB, ADDI, LW, SW, BEQ, BNE, JAL and JALR. It stalls on a memory-ready handshake. Unsupported encodings park the FSM in a sticky illegal state.

## Interface
- No parameters; datapath widths are fixed at 32 bits.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  IR[6:0]; stable from DECODE until the next FETCH
- funct3  in  3  IR[14:12]
- funct7  in  1  IR[30]
- Zero  in  1  ALU zero flag, combinational from the current ALU operation
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  load PC from Result
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write request
- IRWrite  out  1  load IR and OldPC
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A (rs1)
- ALUSrcB  out  2  00 = B (rs2), 01 = imm, 10 = constant 4
- ALUControl  out  3  001 = add, 000 = subtract
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  write rd
- Illegal  out  1  FSM is in ILLEGAL
- State  out  4  current state encoding, for debug

## Operation
- One state register with asynchronous reset. Outputs are combinational from the state; in BRANCH they also depend on funct3 and Zero. Any output not listed for a state is 0.
- **FETCH**
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- **DECODE**
  - Drives ALUSrcA=01, ALUSrcB=01, add, so ALUOut = OldPC + imm.
  - ImmSrc = B for op 99, J for op 111, I otherwise.
  - Next state by opcode:
    - op 3 with f3 010 → MEMADR
    - op 35 with f3 010 → MEMADR
    - op 51 with f3 000 → EXECR
    - op 19 with f3 000 → EXECI
    - op 99 with f3 000 or 001 → BRANCH
    - op 111 → JAL
    - op 103 with f3 000 → JALR1
    - anything else → ILLEGAL
- **MEMADR**
  - Drives ALUSrcA=10, ALUSrcB=01, add.
  - ImmSrc = S for op 35, I for op 3.
  - Goes to MEMWRITE if op=35, else MEMREAD.
- **MEMREAD**: AdrSrc=1. Holds until MemReady=1, then goes to MEMWB.
- **MEMWB**: ResultSrc=01, RegWrite=1. Goes to FETCH.
- **MEMWRITE**: AdrSrc=1, MemWrite=1, held while MemReady=0. Goes to FETCH on MemReady=1.
- **EXECR**: ALUSrcA=10, ALUSrcB=00. ALUControl = 000 (SUB) when funct7=1, else 001 (ADD). Goes to ALUWB.
- **EXECI**: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add. Goes to ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1. Goes to FETCH.
- **BRANCH**
  - Drives ALUSrcA=10, ALUSrcB=00, subtract, ResultSrc=00.
  - PCWrite = Zero when funct3=000; PCWrite = ~Zero when funct3=001.
  - Goes to FETCH.
- **JAL**: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, add (ALUOut ← OldPC+4). Goes to ALUWB.
- **JALR1**: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add (ALUOut ← rs1+imm). Goes to JALR2.
- **JALR2**: same outputs as JAL. Goes to ALUWB.
- **ILLEGAL**: Illegal=1, all strobes 0. Sticky; left only via rst_n.

## Timing
- Reset behaviour:
  - rst_n low → state = FETCH immediately, asynchronously.
  - While rst_n is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 and Illegal is 0.
  - The first fetch can complete on the first rising edge after rst_n deasserts, if MemReady=1.
- Cycle counts with zero wait states (MemReady=1):
  - ADD/SUB/ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ/BNE: 3
  - JAL: 4
  - JALR: 5
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs hold steady while waiting.
- MemWrite stays high continuously from MEMWRITE entry until the MemReady=1 cycle inclusive, then drops.
- rst_n asserted mid-instruction: the instruction is aborted, with no further RegWrite/MemWrite/PCWrite. Effects already committed remain.
- PCWrite in BRANCH follows Zero combinationally within that single cycle; Zero in any other state is ignored.

## Test plan
- Reset, then ADDI (op 19, f3 000), MemReady=1 → states FETCH, DECODE, EXECI, ALUWB, FETCH; RegWrite=1 only in cycle 4; PCWrite=1 only in cycle 1.
- ADD then SUB (op 51, funct7 0 then 1) → ALUControl=001 in the first EXECR, 000 in the second; 4 cycles each.
- LW with MemReady low for 3 cycles in MEMREAD → 8 cycles total; AdrSrc=1 throughout the stall; one RegWrite pulse with ResultSrc=01.
- SW with MemReady low for 2 cycles → MemWrite high for exactly 3 consecutive cycles; RegWrite never asserted.
- BEQ with Zero=1 → PCWrite=1 in BRANCH. BNE with Zero=1 → PCWrite=0. BNE with Zero=0 → PCWrite=1. Each takes 3 cycles.
- op 0x7F decoded → ILLEGAL; Illegal=1 held for 10 cycles with MemReady toggling; rst_n pulse → FETCH, Illegal=0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer for a multi-cycle RV32I datapath with a
// single shared memory port. Walks each instruction through FETCH, DECODE and
// the execute/memory/writeback states required by its opcode. Supports ADD,
// SUB, ADDI, LW, SW, BEQ, BNE, JAL and JALR. Any other encoding lands in a
// sticky ILLEGAL state that is left only through reset.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   op/funct3/funct7  instruction fields from IR (funct7 is IR[30])
//   Zero              ALU zero flag; used only in BRANCH
//   MemReady          memory finishes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite   datapath controls
//   Illegal           FSM is parked in ILLEGAL
//   State             current state encoding (debug)
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = IMM_I;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        ResultSrc  = 2'b10;
        IRWrite    = MemReady;
        PCWrite    = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        if (op == OP_BRANCH)   ImmSrc = IMM_B;
        else if (op == OP_JAL) ImmSrc = IMM_J;
        else                   ImmSrc = IMM_I;
        if ((op == OP_LOAD || op == OP_STORE) && funct3 == 3'b010)
          state_d = S_MEMADR;
        else if (op == OP_REG && funct3 == 3'b000)
          state_d = S_EXECR;
        else if (op == OP_IMM && funct3 == 3'b000)
          state_d = S_EXECI;
        else if (op == OP_BRANCH && (funct3 == 3'b000 || funct3 == 3'b001))
          state_d = S_BRANCH;
        else if (op == OP_JAL)
          state_d = S_JAL;
        else if (op == OP_JALR && funct3 == 3'b000)
          state_d = S_JALR1;
        else
          state_d = S_ILLEGAL;
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d    = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = funct7 ? ALU_SUB : ALU_ADD;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_SUB;
        ResultSrc  = 2'b00;
        // BNE (funct3=001) takes the branch on a nonzero difference.
        PCWrite    = (funct3 == 3'b001) ? ~Zero : Zero;
        state_d    = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        ResultSrc  = 2'b00;
        PCWrite    = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        state_d    = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        state_d    = S_JALR2;
      end
      S_ILLEGAL: begin
        Illegal = 1'b1;
      end
      default: state_d = S_ILLEGAL;
    endcase

    // The state register already reads FETCH during reset; this also masks
    // the MemReady-driven strobes of FETCH until reset is released.
    if (!rst_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each cycle's expected control word
// is queued as the stimulus for that cycle is applied, then popped and
// compared against the DUT at the falling clock edge.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       Illegal;
  logic [3:0] State;

  multicycle_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct3    (funct3),
    .funct7    (funct7),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .ImmSrc    (ImmSrc),
    .RegWrite  (RegWrite),
    .Illegal   (Illegal),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2,
                         MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
                         EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8,
                         BRANCH = 4'd9, JAL = 4'd10, JALR1 = 4'd11,
                         JALR2 = 4'd12, ILLEGAL = 4'd13;

  // Control word: State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
  // ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, Illegal.
  typedef logic [20:0] cw_t;

  logic [20:0] exp_q[$];
  int unsigned n_total;
  int unsigned n_pass;

  function automatic cw_t pk(input logic [3:0] st, input logic pcw,
                             input logic adr, input logic mw, input logic irw,
                             input logic [1:0] rs, input logic [1:0] sa,
                             input logic [1:0] sb, input logic [2:0] alu,
                             input logic [1:0] imm, input logic rw,
                             input logic ill);
    return {st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  function automatic cw_t e_rst();
    return pk(FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b001, 2'b00, 0, 0);
  endfunction
  function automatic cw_t e_fetch(input logic mr);
    return pk(FETCH, mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 3'b001, 2'b00, 0, 0);
  endfunction
  function automatic cw_t e_decode(input logic [1:0] imm);
    return pk(DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b001, imm, 0, 0);
  endfunction
  function automatic cw_t e_memadr(input logic [1:0] imm);
    return pk(MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, imm, 0, 0);
  endfunction
  function automatic cw_t e_memread();
    return pk(MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
  endfunction
  function automatic cw_t e_memwb();
    return pk(MEMWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);
  endfunction
  function automatic cw_t e_memwrite();
    return pk(MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
  endfunction
  function automatic cw_t e_execr(input logic [2:0] alu);
    return pk(EXECR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 2'b00, 0, 0);
  endfunction
  function automatic cw_t e_execi();
    return pk(EXECI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 2'b00, 0, 0);
  endfunction
  function automatic cw_t e_aluwb();
    return pk(ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);
  endfunction
  function automatic cw_t e_branch(input logic pcw);
    return pk(BRANCH, pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 0, 0);
  endfunction
  function automatic cw_t e_jal(input logic [3:0] st);
    return pk(st, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b001, 2'b00, 0, 0);
  endfunction
  function automatic cw_t e_jalr1();
    return pk(JALR1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 2'b00, 0, 0);
  endfunction
  function automatic cw_t e_ill();
    return pk(ILLEGAL, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1);
  endfunction

  task automatic compare(input string tag);
    cw_t got;
    cw_t exp;
    got = {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegWrite, Illegal};
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s scoreboard empty, observed %h", tag, got);
      return;
    end
    exp = exp_q.pop_front();
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed %h expected %h", tag, got, exp);
  endtask

  // One clock cycle: apply inputs, queue the expected word, check it at the
  // falling edge, then advance past the next rising edge.
  task automatic step(input logic mr, input logic z, input cw_t exp,
                      input string tag);
    MemReady = mr;
    Zero     = z;
    exp_q.push_back(exp);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7);
    op     = o;
    funct3 = f3;
    funct7 = f7;
  endtask

  initial begin
    n_total  = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    MemReady = 1'b1;
    Zero     = 1'b0;
    instr(7'd0, 3'd0, 1'b0);

    // In reset with MemReady high: FETCH but no strobes.
    exp_q.push_back(e_rst());
    @(negedge clk);
    compare("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADDI
    instr(7'd19, 3'b000, 1'b0);
    step(1, 0, e_fetch(1), "addi_fetch");
    step(1, 0, e_decode(2'b00), "addi_decode");
    step(1, 0, e_execi(), "addi_exec");
    step(1, 0, e_aluwb(), "addi_wb");

    // ADD then SUB
    instr(7'd51, 3'b000, 1'b0);
    step(1, 0, e_fetch(1), "add_fetch");
    step(1, 0, e_decode(2'b00), "add_decode");
    step(1, 0, e_execr(3'b001), "add_exec");
    step(1, 0, e_aluwb(), "add_wb");
    instr(7'd51, 3'b000, 1'b1);
    step(1, 0, e_fetch(1), "sub_fetch");
    step(1, 0, e_decode(2'b00), "sub_decode");
    step(1, 1, e_execr(3'b000), "sub_exec");
    step(1, 0, e_aluwb(), "sub_wb");

    // LW with a one-cycle fetch stall and three MEMREAD wait cycles
    instr(7'd3, 3'b010, 1'b0);
    step(0, 0, e_fetch(0), "lw_fetch_wait");
    step(1, 0, e_fetch(1), "lw_fetch");
    step(1, 0, e_decode(2'b00), "lw_decode");
    step(1, 0, e_memadr(2'b00), "lw_memadr");
    for (int i = 0; i < 3; i++) step(0, 0, e_memread(), "lw_memread_wait");
    step(1, 0, e_memread(), "lw_memread");
    step(1, 0, e_memwb(), "lw_wb");

    // SW with two MEMWRITE wait cycles
    instr(7'd35, 3'b010, 1'b0);
    step(1, 0, e_fetch(1), "sw_fetch");
    step(1, 0, e_decode(2'b00), "sw_decode");
    step(1, 0, e_memadr(2'b01), "sw_memadr");
    step(0, 0, e_memwrite(), "sw_write_wait1");
    step(0, 0, e_memwrite(), "sw_write_wait2");
    step(1, 0, e_memwrite(), "sw_write");

    // BEQ taken, BNE not taken, BNE taken
    instr(7'd99, 3'b000, 1'b0);
    step(1, 0, e_fetch(1), "beq_fetch");
    step(1, 0, e_decode(2'b10), "beq_decode");
    step(1, 1, e_branch(1), "beq_z1");
    instr(7'd99, 3'b001, 1'b0);
    step(1, 1, e_fetch(1), "bne_fetch");
    step(1, 1, e_decode(2'b10), "bne_decode");
    step(1, 1, e_branch(0), "bne_z1");
    step(1, 0, e_fetch(1), "bne2_fetch");
    step(1, 0, e_decode(2'b10), "bne2_decode");
    step(1, 0, e_branch(1), "bne_z0");

    // JAL
    instr(7'd111, 3'b101, 1'b0);
    step(1, 0, e_fetch(1), "jal_fetch");
    step(1, 0, e_decode(2'b11), "jal_decode");
    step(1, 0, e_jal(JAL), "jal_jal");
    step(1, 0, e_aluwb(), "jal_wb");

    // JALR
    instr(7'd103, 3'b000, 1'b0);
    step(1, 0, e_fetch(1), "jalr_fetch");
    step(1, 0, e_decode(2'b00), "jalr_decode");
    step(1, 0, e_jalr1(), "jalr_1");
    step(1, 0, e_jal(JALR2), "jalr_2");
    step(1, 0, e_aluwb(), "jalr_wb");

    // SW aborted by reset while waiting in MEMWRITE
    instr(7'd35, 3'b010, 1'b0);
    step(1, 0, e_fetch(1), "abort_fetch");
    step(1, 0, e_decode(2'b00), "abort_decode");
    step(1, 0, e_memadr(2'b01), "abort_memadr");
    step(0, 0, e_memwrite(), "abort_memwrite");
    MemReady = 1'b1;
    rst_n    = 1'b0;
    #1;
    exp_q.push_back(e_rst());
    compare("abort_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Unsupported opcode: sticky ILLEGAL, then cleared by reset
    instr(7'h7F, 3'b000, 1'b0);
    step(1, 0, e_fetch(1), "ill_fetch");
    step(1, 0, e_decode(2'b00), "ill_decode");
    for (int i = 0; i < 10; i++) step(i[0], i[1], e_ill(), "ill_hold");
    rst_n = 1'b0;
    #1;
    exp_q.push_back(e_rst());
    compare("ill_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    instr(7'd19, 3'b000, 1'b0);
    step(1, 0, e_fetch(1), "post_fetch");
    step(1, 0, e_decode(2'b00), "post_decode");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
